alu_result_tx: RTL and testbench
================================

Name: alu_result_tx

Overview:
- Serializes one ALU result and its 4-bit flag vector {V,N,Z,P} back to the host over the UART TX line.
- Return path of the UART ALU: the adder/ALU output feeds this block, and the host-side receiver consumes it.
- Sends ceil(N/8) result bytes, MSB byte first, then one flags byte; 8N1 framing, LSB first.

Parameters:
- N, 16, result width; must be a multiple of 8 (elaboration error otherwise).
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); must be ≥ 2.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request to send; accepted only when busy=0.
- result  input  N  signed ALU result; sampled on accept.
- flags  input  4  {V,N,Z,P} from the ALU; sampled on accept.
- tx  output  1  UART serial line; idles high.
- busy  output  1  high from accept through the end of the last stop bit.
- done  output  1  one-cycle pulse when the frame completes.

Behaviour:
- Reset: tx=1, busy=0, done=0, state=IDLE, all counters and shadow registers cleared.
  - Reset takes effect immediately, including mid-frame: tx returns high, and the partial frame is abandoned with no done pulse.
- Accept: at a rising edge with start=1 and busy=0:
  - result and flags are captured into shadow registers; later input changes are ignored.
  - busy goes to 1 and tx goes to 0 (start bit) at that same edge.
  - start while busy=1 is ignored; no queueing.
- Byte order: result[N-1:N-8] … result[7:0], then {4'b0000, flags}. Total BYTES = N/8 + 1.
- Per byte: start bit (0), data bits d0..d7, stop bit (1). Each bit is held exactly CLKS_PER_BIT cycles.
- Bytes are sent back-to-back: the next start bit immediately follows the previous stop bit, with no idle gap.
- Frame length: BYTES*10*CLKS_PER_BIT cycles from the accept edge to the edge at which busy falls.
- At that edge: busy=0 and done=1 for one cycle; tx stays 1.
- Back-to-back frames: start=1 in the cycle done=1 is accepted (busy is already 0). The new start bit begins with no extra idle bit.
- FSM states: IDLE → START → DATA (bit index 0..7) → STOP → (START if more bytes remain, else IDLE).
- Counters:
  - baud counter, 0..CLKS_PER_BIT-1, wraps at the end of each bit;
  - bit index, 0..7;
  - byte index, 0..BYTES-1.
- tx is driven from a register; no combinational path from inputs to tx.

Optional Feature:
- Macro ALU_RESULT_TX_PARITY_EN.
- Defined: each byte carries an even-parity bit after d7 and before the stop bit (11 bits per byte). The parity bit is the XOR of the 8 data bits, so the total count of ones is even, matching the ALU P-flag convention. Frame length becomes BYTES*11*CLKS_PER_BIT cycles.
- Undefined: no parity bit, 8N1, 10 bits per byte.

Decomposition:
- Package alu_uart_pkg holds:
  - flag bit indices FLAG_V=3, FLAG_N=2, FLAG_Z=1, FLAG_P=0;
  - FSM state encodings;
  - UART constants START_BIT=0, STOP_BIT=1.
- Sub-module uart_tx_byte: a single-byte serializer with load/busy/done, baud counter, and optional parity. alu_result_tx is the frame sequencer (byte mux, byte index, shadow registers) around one instance.

Test Plan (CLKS_PER_BIT=4, N=16):
- Basic frame: result=16'h8001, flags=4'b0101, start pulse.
  - Decoded bytes 0x80, 0x01, 0x05.
  - busy high for exactly 120 cycles.
  - done pulses once at cycle 120.
- Capture: change result to 16'hFFFF one cycle after accept → transmitted bytes remain 0x80, 0x01, 0x05.
- Start while busy: pulse start at cycle 50 of a frame → ignored; only one frame sent; busy does not extend.
- Back-to-back: hold start=1 continuously with result=16'h7FFF, flags=4'b1000.
  - Second frame starts in the done cycle with no idle bit.
  - Bytes decode 0x7F, 0xFF, 0x08 twice.
- Reset mid-frame: assert rst during byte 2, bit d3 → tx=1 and busy=0 immediately; no done; the next start sends a clean full frame.
- Parity (ALU_RESULT_TX_PARITY_EN): result=16'h0003, flags=4'b0011.
  - Parity bits 0, 0, 0.
  - 11 bits per byte; frame length 132 cycles.

Source files
------------

// File: rtl/alu_uart_pkg.sv
// Shared constants for the UART ALU return path: flag bit positions, UART line levels
// and the byte serializer state encoding.
package alu_uart_pkg;

  localparam int FLAG_V = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_P = 0;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_e;

  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// Single-byte UART serializer, LSB first. ALU_RESULT_TX_PARITY_EN adds an even-parity bit.
// A load during the last cycle of the stop bit chains the next byte with no idle gap.
//   state     | meaning
//   TX_IDLE   | line high, waiting for load_i
//   TX_START  | driving the start bit
//   TX_DATA   | driving data bit bit_q (0..7)
//   TX_PARITY | driving the even-parity bit (parity build only)
//   TX_STOP   | driving the stop bit
module uart_tx_byte
  import alu_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic [7:0] data_i,
  output logic       tx_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       last_o
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);

  tx_state_e   state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shreg_q, shreg_d;
  logic        tx_q, tx_d;
  logic        done_q, done_d;
  logic        bit_end;
  logic        accept;
`ifdef ALU_RESULT_TX_PARITY_EN
  logic        par_q, par_d;
`endif

  assign bit_end = (baud_q == BAUD_MAX);
  assign last_o  = (state_q == TX_STOP) && bit_end;
  assign accept  = load_i && ((state_q == TX_IDLE) || last_o);
  assign busy_o  = (state_q != TX_IDLE);
  assign tx_o    = tx_q;
  assign done_o  = done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= TX_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      tx_q    <= STOP_BIT;
      done_q  <= 1'b0;
`ifdef ALU_RESULT_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
`ifdef ALU_RESULT_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    tx_d    = tx_q;
    done_d  = 1'b0;
`ifdef ALU_RESULT_TX_PARITY_EN
    par_d   = par_q;
`endif

    if (state_q != TX_IDLE) begin
      baud_d = bit_end ? '0 : baud_q + 1'b1;
    end

    case (state_q)
      TX_IDLE: ;
      TX_START: begin
        if (bit_end) begin
          state_d = TX_DATA;
          bit_d   = '0;
          tx_d    = shreg_q[0];
          shreg_d = {1'b0, shreg_q[7:1]};
        end
      end
      TX_DATA: begin
        if (bit_end) begin
          if (bit_q == 3'd7) begin
`ifdef ALU_RESULT_TX_PARITY_EN
            state_d = TX_PARITY;
            tx_d    = par_q;
`else
            state_d = TX_STOP;
            tx_d    = STOP_BIT;
`endif
          end else begin
            bit_d   = bit_q + 3'd1;
            tx_d    = shreg_q[0];
            shreg_d = {1'b0, shreg_q[7:1]};
          end
        end
      end
      TX_PARITY: begin
        if (bit_end) begin
          state_d = TX_STOP;
          tx_d    = STOP_BIT;
        end
      end
      TX_STOP: begin
        if (bit_end && !load_i) begin
          state_d = TX_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = TX_IDLE;
    endcase

    // A chained load overrides the stop-bit exit so the next start bit follows directly.
    if (accept) begin
      state_d = TX_START;
      baud_d  = '0;
      bit_d   = '0;
      shreg_d = data_i;
      tx_d    = START_BIT;
`ifdef ALU_RESULT_TX_PARITY_EN
      par_d   = even_parity(data_i);
`endif
    end
  end

endmodule

// File: rtl/alu_result_tx.sv
// Frame sequencer: captures an ALU result plus {V,N,Z,P} and sends it MSB byte first, then
// the flags byte, through one uart_tx_byte. ALU_RESULT_TX_PARITY_EN enables per-byte parity.
module alu_result_tx
  import alu_uart_pkg::*;
#(
  parameter int N            = 16,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] result,
  input  logic [3:0]   flags,
  output logic         tx,
  output logic         busy,
  output logic         done
);

  localparam int BYTES = N / 8 + 1;
  localparam int IW    = $clog2(BYTES);

  generate
    if ((N < 8) || (N % 8 != 0)) begin : g_bad_n
      $error("alu_result_tx: N must be a positive multiple of 8");
    end
    if (CLKS_PER_BIT < 2) begin : g_bad_cpb
      $error("alu_result_tx: CLKS_PER_BIT must be at least 2");
    end
  endgenerate

  logic [N+7:0]  frame_q, frame_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [N+7:0]  full;
  logic [3:0]    flags_vec;
  logic          byte_busy, byte_last, byte_load;
  logic [7:0]    byte_data;
  logic          accept, chain;

  assign flags_vec = {flags[FLAG_V], flags[FLAG_N], flags[FLAG_Z], flags[FLAG_P]};
  assign full      = {result, 4'b0000, flags_vec};
  assign accept    = start && !byte_busy;
  assign chain     = byte_last && (idx_q != IW'(BYTES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_q <= '0;
      idx_q   <= '0;
    end else begin
      frame_q <= frame_d;
      idx_q   <= idx_d;
    end
  end

  // The first byte bypasses the shadow; the shadow then holds the remaining bytes, next one on top.
  always_comb begin
    frame_d   = frame_q;
    idx_d     = idx_q;
    byte_load = 1'b0;
    byte_data = frame_q[N+7 -: 8];
    if (accept) begin
      byte_load = 1'b1;
      byte_data = result[N-1 -: 8];
      frame_d   = {full[N-1:0], 8'h00};
      idx_d     = '0;
    end else if (chain) begin
      byte_load = 1'b1;
      frame_d   = {frame_q[N-1:0], 8'h00};
      idx_d     = idx_q + 1'b1;
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte (
    .clk    (clk),
    .rst    (rst),
    .load_i (byte_load),
    .data_i (byte_data),
    .tx_o   (tx),
    .busy_o (byte_busy),
    .done_o (done),
    .last_o (byte_last)
  );

  assign busy = byte_busy;

endmodule

// File: tb/tb_alu_result_tx.sv
// Scoreboard bench for alu_result_tx (N=16, CLKS_PER_BIT=4); a UART monitor decodes tx
// and compares each byte against the expected queue filled by the stimulus.
module tb_alu_result_tx;

  localparam int CPB = 4;
`ifdef ALU_RESULT_TX_PARITY_EN
  localparam int BPB = 11;
`else
  localparam int BPB = 10;
`endif
  localparam int FRAME  = 3 * BPB * CPB;
  localparam int LIMIT  = 2000;
  localparam int RST_AT = 2 * BPB * CPB + 4 * CPB + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] result = '0;
  logic [3:0]  flags = '0;
  logic        tx, busy, done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] b;
    logic       p;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  alu_result_tx #(
    .N(16),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .result (result),
    .flags  (flags),
    .tx     (tx),
    .busy   (busy),
    .done   (done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push_byte(input logic [7:0] b, input logic p);
    exp_t e;
    e.b = b;
    e.p = p;
    exp_q.push_back(e);
  endtask

  task automatic wait_neg(input int n, output bit ab);
    ab = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (rst) ab = 1'b1;
    end
  endtask

  // UART monitor: samples each bit near its middle, abandons a byte on reset.
  initial begin : monitor
    logic [7:0] d;
    logic       s, p;
    bit         ab;
    exp_t       e;
    forever begin
      @(negedge clk);
      if (!rst && tx === 1'b0) begin
        d = '0;
        p = 1'b0;
        wait_neg(1, ab);
        for (int i = 0; i < 8; i++) begin
          if (!ab) begin
            wait_neg(CPB, ab);
            d[i] = tx;
          end
        end
`ifdef ALU_RESULT_TX_PARITY_EN
        if (!ab) begin
          wait_neg(CPB, ab);
          p = tx;
        end
`endif
        s = 1'b0;
        if (!ab) begin
          wait_neg(CPB, ab);
          s = tx;
        end
        if (!ab) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_byte actual=%0h required=none", d);
          end else begin
            e = exp_q.pop_front();
            check("byte", {24'h0, d}, {24'h0, e.b});
            check("stop_bit", {31'h0, s}, 32'h1);
`ifdef ALU_RESULT_TX_PARITY_EN
            check("parity_bit", {31'h0, p}, {31'h0, e.p});
`endif
          end
        end
      end
    end
  end

  task automatic run_frame(input logic [15:0] r, input logic [3:0] f, input int poke_at,
                           input bit poke_start, output int len, output int dn);
    result = r;
    flags  = f;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("accept_tx", {31'h0, tx}, 32'h0);
    check("accept_busy", {31'h0, busy}, 32'h1);
    len = 0;
    dn  = 0;
    while (busy === 1'b1 && len < LIMIT) begin
      if (done === 1'b1) dn++;
      len++;
      if (len == poke_at) begin
        result = 16'hFFFF;
        start  = poke_start;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic check_end(input string name, input int len, input int dn);
    check({name, "_busy_len"}, len, FRAME);
    check({name, "_early_done"}, dn, 0);
    check({name, "_done"}, {31'h0, done}, 32'h1);
    check({name, "_tx_idle"}, {31'h0, tx}, 32'h1);
    @(negedge clk);
    check({name, "_done_pulse"}, {31'h0, done}, 32'h0);
    check({name, "_busy_after"}, {31'h0, busy}, 32'h0);
  endtask

  initial begin : stim
    int len, dn, n;
    repeat (3) @(negedge clk);
    check("rst_tx", {31'h0, tx}, 32'h1);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_done", {31'h0, done}, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // basic frame
    push_byte(8'h80, 1'b1); push_byte(8'h01, 1'b1); push_byte(8'h05, 1'b0);
    run_frame(16'h8001, 4'b0101, 0, 1'b0, len, dn);
    check_end("basic", len, dn);

    // input change one cycle after accept
    push_byte(8'h80, 1'b1); push_byte(8'h01, 1'b1); push_byte(8'h05, 1'b0);
    run_frame(16'h8001, 4'b0101, 1, 1'b0, len, dn);
    check_end("capture", len, dn);

    // start while busy is ignored
    push_byte(8'h12, 1'b0); push_byte(8'h34, 1'b1); push_byte(8'h02, 1'b1);
    run_frame(16'h1234, 4'b0010, 50, 1'b1, len, dn);
    check_end("ignore", len, dn);
    n = 0;
    for (int i = 0; i < 50; i++) begin
      if (busy !== 1'b0) n++;
      @(negedge clk);
    end
    check("ignore_no_queue", n, 0);

    // back-to-back frames with start held high
    push_byte(8'h7F, 1'b1); push_byte(8'hFF, 1'b0); push_byte(8'h08, 1'b1);
    push_byte(8'h7F, 1'b1); push_byte(8'hFF, 1'b0); push_byte(8'h08, 1'b1);
    result = 16'h7FFF;
    flags  = 4'b1000;
    start  = 1'b1;
    @(negedge clk);
    check("b2b_tx0", {31'h0, tx}, 32'h0);
    n = 0;
    while (busy === 1'b1 && n < LIMIT) begin
      n++;
      @(negedge clk);
    end
    check("b2b_len1", n, FRAME);
    check("b2b_done1", {31'h0, done}, 32'h1);
    @(negedge clk);
    check("b2b_restart_busy", {31'h0, busy}, 32'h1);
    check("b2b_restart_tx", {31'h0, tx}, 32'h0);
    start = 1'b0;
    n = 1;
    @(negedge clk);
    while (busy === 1'b1 && n < LIMIT) begin
      n++;
      @(negedge clk);
    end
    check("b2b_len2", n, FRAME);
    check("b2b_done2", {31'h0, done}, 32'h1);
    @(negedge clk);

    // reset during byte 2, bit d3
    push_byte(8'h5A, 1'b0); push_byte(8'h3C, 1'b0); push_byte(8'h01, 1'b1);
    result = 16'h5A3C;
    flags  = 4'b0001;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (RST_AT) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_tx", {31'h0, tx}, 32'h1);
    check("midrst_busy", {31'h0, busy}, 32'h0);
    check("midrst_bytes_sent", exp_q.size(), 1);
    exp_q.delete();
    dn = 0;
    repeat (3) begin
      @(negedge clk);
      if (done !== 1'b0) dn++;
    end
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (done !== 1'b0) dn++;
    end
    check("midrst_no_done", dn, 0);
    push_byte(8'h80, 1'b1); push_byte(8'h01, 1'b1); push_byte(8'h05, 1'b0);
    run_frame(16'h8001, 4'b0101, 0, 1'b0, len, dn);
    check_end("after_rst", len, dn);

`ifdef ALU_RESULT_TX_PARITY_EN
    push_byte(8'h00, 1'b0); push_byte(8'h03, 1'b0); push_byte(8'h03, 1'b0);
    run_frame(16'h0003, 4'b0011, 0, 1'b0, len, dn);
    check_end("parity", len, dn);
`endif

    repeat (20) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
